// File: rtl/reg_dump_reader.sv
// reg_dump_reader: steps through all 32 register-file addresses and presents each value on a valid/ready port.
// With SKIP_ZERO set, registers that read as zero are passed over without producing an entry.
module reg_dump_reader #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_idx,
    output logic [31:0] out_data,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;
    state_t     state;
    logic [4:0] idx;
    assign rd_addr = idx;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort && state != IDLE) begin
            state     <= IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    state <= READ;
                    busy  <= 1'b1;
                end
                READ: if (SKIP_ZERO && rd_data == 32'h0) begin
                    if (idx == 5'd31) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else idx <= idx + 5'd1;
                end else begin
                    out_data  <= rd_data;
                    out_idx   <= idx;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    if (idx == 5'd31) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + 5'd1;
                        state <= READ;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed tests for reg_dump_reader with SKIP_ZERO=0 (dut0) and SKIP_ZERO=1 (dut1).
module tb_reg_dump_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] regs0 [32];
    logic [31:0] regs1 [32];
    logic [4:0]  rd_addr0, rd_addr1, out_idx0, out_idx1;
    logic [31:0] rd_data0, rd_data1, out_data0, out_data1;
    logic        out_valid0, out_valid1, busy0, busy1, done0, done1;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;
    assign rd_data0 = regs0[rd_addr0];
    assign rd_data1 = regs1[rd_addr1];

    reg_dump_reader #(.SKIP_ZERO(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .abort(abort),
        .rd_addr(rd_addr0), .rd_data(rd_data0), .out_valid(out_valid0), .out_ready(out_ready),
        .out_idx(out_idx0), .out_data(out_data0), .busy(busy0), .done(done0)
    );

    reg_dump_reader #(.SKIP_ZERO(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .abort(abort),
        .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(out_valid1), .out_ready(out_ready),
        .out_idx(out_idx1), .out_data(out_data1), .busy(busy1), .done(done1)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Leaves the bench at the negedge after E0 with start already dropped.
    task automatic pulse_start0();
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic wait_entry0(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            ok = out_valid0 && out_idx0 == 5'(n);
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({busy0, done0, out_valid0, rd_addr0, out_idx0, out_data0} !== 45'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b valid=%b addr=%0d idx=%0d data=%h, want all zero",
                     busy0, done0, out_valid0, rd_addr0, out_idx0, out_data0);
        end
        do_reset();
        abort = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        checks++;
        if (busy0 !== 1'b0) begin
            errors++;
            $display("FAIL idle_start_abort: busy=%b want 0", busy0);
        end
        abort = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic test_full_dump();
        int entries = 0;
        int n;
        for (int i = 0; i < 32; i++) regs0[i] = 32'(i) * 32'h0101;
        out_ready = 1'b1;
        do_reset();
        pulse_start0();
        checks++;
        if (busy0 !== 1'b1 || rd_addr0 !== 5'd0) begin
            errors++;
            $display("FAIL full_first_read: busy=%b addr=%0d want 1 0", busy0, rd_addr0);
        end
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            checks++;
            if (done0 !== logic'(k == 64)) begin
                errors++;
                $display("FAIL full_done k=%0d: done=%b want %b", k, done0, k == 64);
            end
            checks++;
            if (busy0 !== logic'(k <= 64)) begin
                errors++;
                $display("FAIL full_busy k=%0d: busy=%b want %b", k, busy0, k <= 64);
            end
            if (k % 2 == 1 && k < 64) begin
                n = (k - 1) / 2;
                checks++;
                if (out_valid0 !== 1'b1 || out_idx0 !== 5'(n) || out_data0 !== 32'(n) * 32'h0101 || rd_addr0 !== 5'(n)) begin
                    errors++;
                    $display("FAIL full_entry k=%0d: valid=%b idx=%0d data=%h addr=%0d want 1 %0d %h %0d",
                             k, out_valid0, out_idx0, out_data0, rd_addr0, n, 32'(n) * 32'h0101, n);
                end
                if (out_valid0) entries++;
            end else if (k < 64) begin
                checks++;
                if (out_valid0 !== 1'b0) begin
                    errors++;
                    $display("FAIL full_gap k=%0d: valid=%b want 0", k, out_valid0);
                end
            end
            if (k == 11) begin
                checks++;
                if (out_data0 !== 32'h0505) begin
                    errors++;
                    $display("FAIL full_r5: data=%h want 00000505", out_data0);
                end
            end
        end
        checks++;
        if (entries != 32) begin
            errors++;
            $display("FAIL full_count: entries=%0d want 32", entries);
        end
        checks++;
        if (rd_addr0 !== 5'd0) begin
            errors++;
            $display("FAIL full_idle_addr: addr=%0d want 0", rd_addr0);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        out_ready = 1'b1;
        pulse_start0();
        wait_entry0(3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL bp_reach3: entry 3 not seen, want seen");
        end
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (out_valid0 !== 1'b1 || out_idx0 !== 5'd3 || out_data0 !== 32'h0303) begin
                errors++;
                $display("FAIL bp_hold c=%0d: valid=%b idx=%0d data=%h want 1 3 00000303",
                         c, out_valid0, out_idx0, out_data0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b0 || rd_addr0 !== 5'd4) begin
            errors++;
            $display("FAIL bp_accept: valid=%b addr=%0d want 0 4", out_valid0, rd_addr0);
        end
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b1 || out_idx0 !== 5'd4 || out_data0 !== 32'h0404) begin
            errors++;
            $display("FAIL bp_next: valid=%b idx=%0d data=%h want 1 4 00000404", out_valid0, out_idx0, out_data0);
        end
    endtask

    task automatic test_abort();
        bit ok;
        bit seen_done = 1'b0;
        do_reset();
        out_ready = 1'b1;
        pulse_start0();
        wait_entry0(12, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abort_reach12: entry 12 not seen, want seen");
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy0 !== 1'b0 || out_valid0 !== 1'b0 || rd_addr0 !== 5'd0 || done0 !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle: busy=%b valid=%b addr=%0d done=%b want 0 0 0 0",
                     busy0, out_valid0, rd_addr0, done0);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            seen_done |= done0 | busy0;
        end
        checks++;
        if (seen_done) begin
            errors++;
            $display("FAIL abort_quiet: done/busy seen=1 want 0");
        end
        pulse_start0();
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b1 || out_idx0 !== 5'd0 || out_data0 !== 32'h0) begin
            errors++;
            $display("FAIL abort_restart: valid=%b idx=%0d data=%h want 1 0 0", out_valid0, out_idx0, out_data0);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen = 1'b0;
        do_reset();
        out_ready = 1'b1;
        pulse_start0();
        wait_entry0(20, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_reach20: entry 20 not seen, want seen");
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy0, done0, out_valid0, rd_addr0, out_idx0, out_data0} !== 45'h0) begin
            errors++;
            $display("FAIL rst_async: busy=%b done=%b valid=%b addr=%0d idx=%0d data=%h want all zero",
                     busy0, done0, out_valid0, rd_addr0, out_idx0, out_data0);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen |= done0 | busy0;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_quiet: done/busy seen=1 want 0");
        end
        pulse_start0();
        wait_entry0(2, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rst_reach2: entry 2 not seen, want seen");
        end
        pulse_start0();
        checks++;
        if (busy0 !== 1'b1 || rd_addr0 !== 5'd3) begin
            errors++;
            $display("FAIL busy_start_ignored: busy=%b addr=%0d want 1 3", busy0, rd_addr0);
        end
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b1 || out_idx0 !== 5'd3) begin
            errors++;
            $display("FAIL busy_seq3: valid=%b idx=%0d want 1 3", out_valid0, out_idx0);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (out_valid0 !== 1'b1 || out_idx0 !== 5'd4) begin
            errors++;
            $display("FAIL busy_seq4: valid=%b idx=%0d want 1 4", out_valid0, out_idx0);
        end
    endtask

    task automatic test_skip_zero();
        int got [$];
        for (int i = 0; i < 32; i++) regs1[i] = 32'h0;
        regs1[7] = 32'hDEADBEEF;
        regs1[31] = 32'h1;
        out_ready = 1'b1;
        do_reset();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (out_valid1) begin
                got.push_back(int'(out_idx1));
                checks++;
                if (out_data1 !== (out_idx1 == 5'd7 ? 32'hDEADBEEF : 32'h1)) begin
                    errors++;
                    $display("FAIL skip_data idx=%0d: data=%h want %h", out_idx1, out_data1,
                             out_idx1 == 5'd7 ? 32'hDEADBEEF : 32'h1);
                end
            end
            checks++;
            if (done1 !== logic'(k == 34)) begin
                errors++;
                $display("FAIL skip_done k=%0d: done=%b want %b", k, done1, k == 34);
            end
        end
        checks++;
        if (got.size() != 2 || got[0] != 7 || got[1] != 31) begin
            errors++;
            $display("FAIL skip_entries: count=%0d first=%0d last=%0d want 2 7 31", got.size(),
                     got.size() > 0 ? got[0] : -1, got.size() > 1 ? got[1] : -1);
        end
        checks++;
        if (busy1 !== 1'b0) begin
            errors++;
            $display("FAIL skip_idle: busy=%b want 0", busy1);
        end
    endtask

    task automatic test_skip_all_zero();
        bit seen_valid = 1'b0;
        for (int i = 0; i < 32; i++) regs1[i] = 32'h0;
        do_reset();
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            seen_valid |= out_valid1;
            checks++;
            if (done1 !== logic'(k == 32)) begin
                errors++;
                $display("FAIL zero_done k=%0d: done=%b want %b", k, done1, k == 32);
            end
        end
        checks++;
        if (seen_valid || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL zero_quiet: valid_seen=%b busy=%b want 0 0", seen_valid, busy1);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            regs0[i] = 32'(i) * 32'h0101;
            regs1[i] = 32'h0;
        end
        test_reset();
        test_full_dump();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_skip_zero();
        test_skip_all_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_dump_reader.md
REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 Parameter: SKIP_ZERO, default 0, when 1 registers reading 32'h0 are not emitted.
REQ-002 clk  input  1  system clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a full register-file dump; sampled on posedge.
REQ-005 abort  input  1  synchronous cancel of a dump in progress.
REQ-006 rd_addr  output  5  read address driven to the register file read port.
REQ-007 rd_data  input  32  combinational register file read data for rd_addr, same cycle.
REQ-008 out_valid  output  1  out_idx/out_data hold a dumped entry.
REQ-009 out_ready  input  1  consumer accepts the entry.
REQ-010 out_idx  output  5  register number of the current entry.
REQ-011 out_data  output  32  register value of the current entry.
REQ-012 busy  output  1  dump in progress (state not IDLE).
REQ-013 done  output  1  one-cycle pulse at dump completion.

Function
REQ-014 The block SHALL be an FSM with states IDLE, READ, HOLD, DONE and a 5-bit index counter idx.
REQ-015 rd_addr SHALL equal idx in every state; idx is 0 in IDLE.
REQ-016 IDLE: start=1 at a posedge -> READ with idx=0; start while not IDLE SHALL be ignored.
REQ-017 READ: at posedge capture out_data<=rd_data, out_idx<=idx, set out_valid=1, go HOLD.
REQ-018 READ with SKIP_ZERO=1 and rd_data==0: no capture; idx<31 -> idx+1, stay READ; idx==31 -> DONE.
REQ-019 HOLD: out_valid, out_idx, out_data SHALL remain stable until a posedge with out_ready=1.
REQ-020 HOLD handshake (out_valid&out_ready at posedge): out_valid<=0; idx==31 -> DONE, else idx+1 -> READ.
REQ-021 idx SHALL never wrap; index 31 is always the last address visited.
REQ-022 DONE: done=1 for exactly that cycle, then IDLE unconditionally; start in DONE ignored.
REQ-023 Register 0 SHALL be read like any other (value 0 expected, not forced).
REQ-024 Values are those present on rd_data at the capture posedge; writes to the register file during a dump are not tracked.
REQ-025 Timing with out_ready held 1, SKIP_ZERO=0: start at edge E0; entry n valid after E(2n+1), accepted at E(2n+2); done high after E64; IDLE after E65.
REQ-026 abort=1 at any posedge in READ/HOLD/DONE SHALL go to IDLE, clear out_valid, idx=0, no done pulse; abort has priority over handshake and start.
REQ-027 abort in IDLE SHALL have no effect; simultaneous start and abort in IDLE SHALL stay IDLE.
REQ-028 busy SHALL be 1 in READ, HOLD, DONE and 0 in IDLE.

Reset
REQ-029 reset=1 SHALL immediately force IDLE, idx=0, rd_addr=0, out_valid=0, out_idx=0, out_data=0, done=0, busy=0, regardless of clk.
REQ-030 reset asserted mid-dump SHALL discard the dump with no done pulse; first start after release begins at idx 0.

Verification
REQ-031 Regfile preloaded r[i]=i*16'h0101, out_ready=1, pulse start -> 32 entries idx 0..31 in order, r5 = 32'h0505, done one cycle after E64, busy low after E65.
REQ-032 out_ready held 0 for 10 cycles in HOLD at idx 3 -> out_valid, out_idx=3, out_data constant for all 10 cycles; release -> idx 4 next entry.
REQ-033 SKIP_ZERO=1, only r7=32'hDEADBEEF and r31=32'h1 nonzero -> exactly two entries (7, 31), then done.
REQ-034 SKIP_ZERO=1, all registers zero -> no out_valid, done pulse after 32 READ cycles.
REQ-035 abort asserted in HOLD at idx 12 -> next cycle IDLE, out_valid=0, no done; new start dumps from idx 0.
REQ-036 reset asserted between edges at idx 20 -> outputs zero immediately; start re-pulsed while busy at idx 2 ignored (sequence continues 3,4,...).
